// File: rtl/program_mem_controller_pkg.sv
// program_mem_controller_pkg
// Shared types and helpers for the program memory controller slice.
//   state_t   : controller FSM encoding (IDLE=0, READ_WAITING=1, RELAYING=2)
//   id_width  : bits needed to hold a channel index (never less than 1)
//   wrap_next : index + 1, wrapping to 0 at the channel count
package program_mem_controller_pkg;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        READ_WAITING = 2'd1,
        RELAYING     = 2'd2
    } state_t;

    function automatic int id_width(input int count);
        return (count > 1) ? $clog2(count) : 1;
    endfunction

    function automatic int wrap_next(input int index, input int modulus);
        return (index + 1 >= modulus) ? 0 : index + 1;
    endfunction

endpackage

// File: rtl/program_mem_controller_if.sv
// program_mem_controller_if
// Bundles the fetcher-side and memory-side handshakes of the controller.
//   consumer_read_valid/address : per-fetcher request and PC
//   consumer_read_ready/data    : per-fetcher response strobe and instruction
//   mem_read_valid/address      : request towards program memory
//   mem_read_ready/data         : program memory response
// Modports:
//   master : the controller (answers fetchers, issues memory requests)
//   slave  : the surroundings (fetchers plus program memory)
interface program_mem_controller_if
    import program_mem_controller_pkg::*;
#(
    parameter int ADDR_BITS     = 8,
    parameter int DATA_BITS     = 16,
    parameter int NUM_CONSUMERS = 4
);

    logic [NUM_CONSUMERS-1:0]                consumer_read_valid;
    logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0] consumer_read_address;
    logic [NUM_CONSUMERS-1:0]                consumer_read_ready;
    logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0] consumer_read_data;
    logic                                    mem_read_valid;
    logic [ADDR_BITS-1:0]                    mem_read_address;
    logic                                    mem_read_ready;
    logic [DATA_BITS-1:0]                    mem_read_data;

    modport master (
        input  consumer_read_valid,
        input  consumer_read_address,
        input  mem_read_ready,
        input  mem_read_data,
        output consumer_read_ready,
        output consumer_read_data,
        output mem_read_valid,
        output mem_read_address
    );

    modport slave (
        output consumer_read_valid,
        output consumer_read_address,
        output mem_read_ready,
        output mem_read_data,
        input  consumer_read_ready,
        input  consumer_read_data,
        input  mem_read_valid,
        input  mem_read_address
    );

endinterface

// File: rtl/program_mem_controller_rr_arbiter.sv
// rr_arbiter
// Purely combinational round-robin pick over the fetcher request vector.
//   request     : one bit per channel, high when that channel wants service
//   rr_ptr      : channel the search starts from
//   grant_valid : high when at least one request bit is set
//   grant_id    : first requesting channel at or after rr_ptr (modulo count)
module rr_arbiter
    import program_mem_controller_pkg::*;
#(
    parameter int NUM_CONSUMERS = 4,
    parameter int ID_BITS       = 2
) (
    input  logic [NUM_CONSUMERS-1:0] request,
    input  logic [ID_BITS-1:0]       rr_ptr,
    output logic                     grant_valid,
    output logic [ID_BITS-1:0]       grant_id
);

    // Walk the channels starting at rr_ptr; the first hit wins and later
    // hits are masked by grant_valid already being set.
    always_comb begin
        grant_valid = 1'b0;
        grant_id    = '0;
        for (int offset = 0; offset < NUM_CONSUMERS; offset++) begin
            if (!grant_valid && request[(int'(rr_ptr) + offset) % NUM_CONSUMERS]) begin
                grant_valid = 1'b1;
                grant_id    = ID_BITS'((int'(rr_ptr) + offset) % NUM_CONSUMERS);
            end
        end
    end

endmodule

// File: rtl/program_mem_controller.sv
// program_mem_controller
// Shares one program memory port between NUM_CONSUMERS instruction fetchers.
// One memory read is outstanding at a time; channels are served round-robin.
// Ports:
//   clk   : rising-edge clock
//   reset : synchronous, active-high; abandons any transaction in flight
//   bus   : program_mem_controller_if.master (fetcher and memory handshakes)
module program_mem_controller
    import program_mem_controller_pkg::*;
#(
    parameter int ADDR_BITS     = 8,
    parameter int DATA_BITS     = 16,
    parameter int NUM_CONSUMERS = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    program_mem_controller_if.master    bus
);

    localparam int ID_BITS = id_width(NUM_CONSUMERS);

    state_t                                  state, state_next;
    logic [ID_BITS-1:0]                      rr_ptr, rr_ptr_next;
    logic [ID_BITS-1:0]                      active_id, active_id_next;
    logic                                    mem_valid_q, mem_valid_next;
    logic [ADDR_BITS-1:0]                    mem_addr_q, mem_addr_next;
    logic [NUM_CONSUMERS-1:0]                ready_q, ready_next;
    logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0] data_q, data_next;

    logic                                    arb_valid;
    logic [ID_BITS-1:0]                      arb_id;

    rr_arbiter #(
        .NUM_CONSUMERS (NUM_CONSUMERS),
        .ID_BITS       (ID_BITS)
    ) arbiter (
        .request     (bus.consumer_read_valid),
        .rr_ptr      (rr_ptr),
        .grant_valid (arb_valid),
        .grant_id    (arb_id)
    );

    // Next-state logic. Every output is registered, so this block computes
    // the next value of each register and everything holds by default.
    // mem_read_ready is only looked at in READ_WAITING, which is exactly when
    // mem_read_valid is high, so stray strobes elsewhere are ignored.
    // Leaving RELAYING only once the granted valid is seen low is what stops
    // a fetcher that is still holding valid from being granted twice.
    always_comb begin
        state_next     = state;
        rr_ptr_next    = rr_ptr;
        active_id_next = active_id;
        mem_valid_next = mem_valid_q;
        mem_addr_next  = mem_addr_q;
        ready_next     = ready_q;
        data_next      = data_q;

        case (state)
            IDLE: begin
                if (arb_valid) begin
                    active_id_next = arb_id;
                    mem_addr_next  = bus.consumer_read_address[arb_id];
                    mem_valid_next = 1'b1;
                    state_next     = READ_WAITING;
                end
            end

            READ_WAITING: begin
                if (bus.mem_read_ready) begin
                    data_next[active_id]  = bus.mem_read_data;
                    ready_next[active_id] = 1'b1;
                    mem_valid_next        = 1'b0;
                    state_next            = RELAYING;
                end
            end

            RELAYING: begin
                if (!bus.consumer_read_valid[active_id]) begin
                    ready_next[active_id] = 1'b0;
                    rr_ptr_next           = ID_BITS'(wrap_next(int'(active_id), NUM_CONSUMERS));
                    state_next            = IDLE;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset. Data registers are
    // cleared on reset too so every fetcher starts from a known word.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            rr_ptr      <= '0;
            active_id   <= '0;
            mem_valid_q <= 1'b0;
            mem_addr_q  <= '0;
            ready_q     <= '0;
            data_q      <= '0;
        end else begin
            state       <= state_next;
            rr_ptr      <= rr_ptr_next;
            active_id   <= active_id_next;
            mem_valid_q <= mem_valid_next;
            mem_addr_q  <= mem_addr_next;
            ready_q     <= ready_next;
            data_q      <= data_next;
        end
    end

    assign bus.mem_read_valid      = mem_valid_q;
    assign bus.mem_read_address    = mem_addr_q;
    assign bus.consumer_read_ready = ready_q;
    assign bus.consumer_read_data  = data_q;

endmodule

// File: tb/tb_program_mem_controller.sv
// tb_program_mem_controller
// Drives fetcher agents and a program memory agent around the controller and
// compares every cycle against a transaction-level reference model. Directed
// scenarios pin the model with hand-computed literals; a random phase follows.
module tb_program_mem_controller;

    localparam int ADDR_BITS     = 8;
    localparam int DATA_BITS     = 16;
    localparam int NUM_CONSUMERS = 4;

    typedef enum {F_IDLE, F_PENDING, F_WAIT, F_HOLD, F_ABANDONED} fetch_state_t;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    program_mem_controller_if #(
        .ADDR_BITS     (ADDR_BITS),
        .DATA_BITS     (DATA_BITS),
        .NUM_CONSUMERS (NUM_CONSUMERS)
    ) bus ();

    program_mem_controller #(
        .ADDR_BITS     (ADDR_BITS),
        .DATA_BITS     (DATA_BITS),
        .NUM_CONSUMERS (NUM_CONSUMERS)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    int testsRun    = 0;
    int testsFailed = 0;

    // reference model: who owns the memory, whether the read is still pending
    int                                      owner;
    bit                                      waiting;
    int                                      rrStart;
    logic                                    expMemValid;
    logic [ADDR_BITS-1:0]                    expMemAddr;
    logic [NUM_CONSUMERS-1:0]                expReady;
    logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0] expData;
    int                                      grantLog[$];

    // agents
    fetch_state_t         fState[NUM_CONSUMERS];
    int                   fCnt[NUM_CONSUMERS];
    int                   fHold[NUM_CONSUMERS];
    int                   autoRepeat[NUM_CONSUMERS];
    bit                   fAbandon[NUM_CONSUMERS];
    logic [ADDR_BITS-1:0] fAddr[NUM_CONSUMERS];
    logic [DATA_BITS-1:0] memArray[256];
    bit                   memActive;
    int                   memCnt;
    int                   curLat;
    int                   memLatency;
    int                   strayLevel;
    bit                   randomMode;
    bit                   resetReq;

    // observations of the DUT
    int                   stepCount;
    int                   readyCycles[NUM_CONSUMERS];
    int                   firstReadyStep[NUM_CONSUMERS];
    logic [DATA_BITS-1:0] lastReadyData[NUM_CONSUMERS];
    int                   memReads;
    logic [ADDR_BITS-1:0] lastMemAddr;
    logic                 prevMemValid;

    task automatic checkValue(input string name, input logic [63:0] actual, input logic [63:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (step %0d)", name, actual, expected, stepCount);
        end
    endtask

    task automatic modelReset();
        owner       = -1;
        waiting     = 1'b0;
        rrStart     = 0;
        expMemValid = 1'b0;
        expMemAddr  = '0;
        expReady    = '0;
        expData     = '0;
    endtask

    // Predicts the registered outputs after the coming rising edge from the
    // inputs that are now stable on the bus.
    task automatic modelUpdate();
        if (reset) begin
            modelReset();
        end else if (owner < 0) begin
            for (int k = 0; k < NUM_CONSUMERS; k++) begin
                if (owner < 0 && bus.consumer_read_valid[(rrStart + k) % NUM_CONSUMERS])
                    owner = (rrStart + k) % NUM_CONSUMERS;
            end
            if (owner >= 0) begin
                waiting     = 1'b1;
                expMemValid = 1'b1;
                expMemAddr  = bus.consumer_read_address[owner];
                grantLog.push_back(owner);
            end
        end else if (waiting) begin
            if (bus.mem_read_ready) begin
                expData[owner]  = bus.mem_read_data;
                expReady[owner] = 1'b1;
                expMemValid     = 1'b0;
                waiting         = 1'b0;
            end
        end else if (!bus.consumer_read_valid[owner]) begin
            expReady[owner] = 1'b0;
            rrStart         = (owner + 1) % NUM_CONSUMERS;
            owner           = -1;
        end
    endtask

    task automatic checkOutput();
        checkValue("mem_read_valid", 64'(bus.mem_read_valid), 64'(expMemValid));
        if (expMemValid)
            checkValue("mem_read_address", 64'(bus.mem_read_address), 64'(expMemAddr));
        checkValue("consumer_read_ready", 64'(bus.consumer_read_ready), 64'(expReady));
        checkValue("consumer_read_data", 64'(bus.consumer_read_data), 64'(expData));
        for (int i = 0; i < NUM_CONSUMERS; i++) begin
            if (bus.consumer_read_ready[i]) begin
                if (readyCycles[i] == 0)
                    firstReadyStep[i] = stepCount;
                readyCycles[i]++;
                lastReadyData[i] = bus.consumer_read_data[i];
            end
        end
        if (bus.mem_read_valid && !prevMemValid) begin
            memReads++;
            lastMemAddr = bus.mem_read_address;
        end
        prevMemValid = bus.mem_read_valid;
    endtask

    task automatic applyStimulus();
        reset = resetReq;
        for (int i = 0; i < NUM_CONSUMERS; i++) begin
            if (fState[i] == F_IDLE) begin
                if (autoRepeat[i] > 0) begin
                    autoRepeat[i]--;
                    fState[i] = F_PENDING;
                end else if (randomMode && $urandom_range(0, 3) == 0) begin
                    fAddr[i]    = 8'($urandom);
                    fHold[i]    = $urandom_range(0, 3);
                    fAbandon[i] = ($urandom_range(0, 7) == 0);
                    fState[i]   = F_PENDING;
                end
            end
            if (fState[i] == F_PENDING) begin
                bus.consumer_read_valid[i]   = 1'b1;
                bus.consumer_read_address[i] = fAddr[i];
                fState[i]                    = F_WAIT;
            end else if (fState[i] == F_WAIT) begin
                if (fAbandon[i] && owner == i && waiting) begin
                    bus.consumer_read_valid[i] = 1'b0;
                    fState[i]                  = F_ABANDONED;
                end else if (expReady[i]) begin
                    fState[i] = F_HOLD;
                    fCnt[i]   = fHold[i];
                end
            end else if (fState[i] == F_ABANDONED) begin
                if (owner != i)
                    fState[i] = F_IDLE;
            end
            if (fState[i] == F_HOLD) begin
                if (fCnt[i] == 0) begin
                    bus.consumer_read_valid[i] = 1'b0;
                    fState[i]                  = F_IDLE;
                end else begin
                    fCnt[i]--;
                end
            end
        end

        if (expMemValid) begin
            if (!memActive) begin
                memActive = 1'b1;
                memCnt    = 0;
                curLat    = randomMode ? $urandom_range(0, 3) : memLatency;
            end
            if (memCnt >= curLat) begin
                bus.mem_read_ready = 1'b1;
                bus.mem_read_data  = memArray[expMemAddr];
                memActive          = 1'b0;
            end else begin
                memCnt++;
                bus.mem_read_ready = 1'b0;
                bus.mem_read_data  = 16'($urandom);
            end
        end else begin
            memActive          = 1'b0;
            bus.mem_read_ready = (strayLevel == 2) || (strayLevel == 1 && $urandom_range(0, 1) == 1);
            bus.mem_read_data  = 16'($urandom);
        end
    endtask

    task automatic step();
        @(negedge clk);
        stepCount++;
        checkOutput();
        applyStimulus();
        modelUpdate();
    endtask

    task automatic runSteps(input int n);
        for (int s = 0; s < n; s++)
            step();
    endtask

    task automatic clearObs();
        for (int i = 0; i < NUM_CONSUMERS; i++) begin
            readyCycles[i]    = 0;
            firstReadyStep[i] = -1;
        end
        memReads = 0;
        grantLog.delete();
    endtask

    task automatic request(input int ch, input logic [ADDR_BITS-1:0] addr, input int hold, input bit abandon);
        fAddr[ch]    = addr;
        fHold[ch]    = hold;
        fAbandon[ch] = abandon;
        fState[ch]   = F_PENDING;
    endtask

    task automatic checkOrder(input string name, input int expected[]);
        checkValue({name, " count"}, 64'(grantLog.size()), 64'(expected.size()));
        for (int k = 0; k < expected.size() && k < grantLog.size(); k++)
            checkValue({name, " entry"}, 64'(grantLog[k]), 64'(expected[k]));
    endtask

    task automatic checkQuiet(input string name);
        checkValue({name, " ready"}, 64'(bus.consumer_read_ready), 64'd0);
        checkValue({name, " mem_valid"}, 64'(bus.mem_read_valid), 64'd0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset                     = 1'b1;
        resetReq                  = 1'b1;
        bus.consumer_read_valid   = '0;
        bus.consumer_read_address = '0;
        bus.mem_read_ready        = 1'b0;
        bus.mem_read_data         = '0;
        for (int i = 0; i < NUM_CONSUMERS; i++) begin
            fState[i]     = F_IDLE;
            fCnt[i]       = 0;
            fHold[i]      = 0;
            autoRepeat[i] = 0;
            fAbandon[i]   = 1'b0;
            fAddr[i]      = '0;
            lastReadyData[i] = '0;
        end
        for (int a = 0; a < 256; a++)
            memArray[a] = 16'($urandom);
        memArray[5]  = 16'h1234;
        memActive    = 1'b0;
        memCnt       = 0;
        curLat       = 0;
        memLatency   = 0;
        strayLevel   = 0;
        randomMode   = 1'b0;
        stepCount    = 0;
        prevMemValid = 1'b0;
        lastMemAddr  = '0;
        modelReset();
        clearObs();

        // reset state
        runSteps(3);
        checkQuiet("reset");
        checkValue("reset data", 64'(bus.consumer_read_data), 64'd0);
        checkValue("reset mem_addr", 64'(bus.mem_read_address), 64'd0);
        resetReq = 1'b0;
        runSteps(2);

        // single read, memory answers two cycles late
        clearObs();
        memLatency = 2;
        request(0, 8'h05, 0, 1'b0);
        runSteps(12);
        checkValue("single memReads", 64'(memReads), 64'd1);
        checkValue("single mem_addr", 64'(lastMemAddr), 64'h05);
        checkValue("single ready width", 64'(readyCycles[0]), 64'd1);
        checkValue("single data", 64'(lastReadyData[0]), 64'h1234);
        checkQuiet("single idle");

        // contention from a fresh reset, ch0 asks again right away
        resetReq = 1'b1;
        runSteps(2);
        resetReq = 1'b0;
        clearObs();
        memLatency = 0;
        for (int i = 0; i < NUM_CONSUMERS; i++)
            request(i, 8'(8'h10 + i), 0, 1'b0);
        autoRepeat[0] = 1;
        runSteps(40);
        checkOrder("contention order", '{0, 1, 2, 3, 0});
        checkValue("contention ch0 ready cycles", 64'(readyCycles[0]), 64'd2);
        for (int i = 1; i < NUM_CONSUMERS; i++)
            checkValue("contention ready cycles", 64'(readyCycles[i]), 64'd1);
        for (int i = 0; i < NUM_CONSUMERS; i++)
            checkValue("contention data", 64'(lastReadyData[i]), 64'(memArray[8'h10 + i]));

        // zero-wait memory, fetcher drops valid one cycle after ready
        clearObs();
        memLatency = 0;
        request(0, 8'h06, 1, 1'b0);
        runSteps(10);
        checkValue("zero-wait ready latency", 64'(firstReadyStep[0] - (stepCount - 10)), 64'd3);
        checkValue("zero-wait ready width", 64'(readyCycles[0]), 64'd2);

        // ch2 holds valid for a while after ready
        clearObs();
        memLatency = 1;
        request(2, 8'h33, 4, 1'b0);
        runSteps(16);
        checkValue("held ready width", 64'(readyCycles[2]), 64'd5);
        checkValue("held memReads", 64'(memReads), 64'd1);
        checkValue("held data", 64'(lastReadyData[2]), 64'(memArray[8'h33]));

        // ch1 gives up while the read is outstanding
        clearObs();
        memLatency = 3;
        request(1, 8'h44, 0, 1'b1);
        runSteps(12);
        checkValue("abandon ready width", 64'(readyCycles[1]), 64'd1);
        checkValue("abandon memReads", 64'(memReads), 64'd1);
        checkValue("abandon data", 64'(lastReadyData[1]), 64'(memArray[8'h44]));
        checkQuiet("abandon idle");

        // reset while ch3's read is outstanding
        clearObs();
        memLatency = 6;
        request(3, 8'hA7, 0, 1'b0);
        runSteps(3);
        resetReq = 1'b1;
        runSteps(1);
        resetReq = 1'b0;
        runSteps(1);
        checkQuiet("midreset");
        checkValue("midreset data", 64'(bus.consumer_read_data), 64'd0);
        runSteps(15);
        checkValue("midreset memReads", 64'(memReads), 64'd2);
        checkValue("midreset mem_addr", 64'(lastMemAddr), 64'hA7);
        checkValue("midreset ready width", 64'(readyCycles[3]), 64'd1);
        checkValue("midreset data", 64'(lastReadyData[3]), 64'(memArray[8'hA7]));
        checkOrder("midreset order", '{3, 3});

        // stray memory strobes with nobody asking
        clearObs();
        strayLevel = 2;
        runSteps(8);
        strayLevel = 0;
        runSteps(1);
        checkValue("stray grants", 64'(grantLog.size()), 64'd0);
        checkValue("stray memReads", 64'(memReads), 64'd0);
        checkQuiet("stray");

        // random traffic, then let everything drain
        randomMode = 1'b1;
        strayLevel = 1;
        runSteps(3000);
        randomMode = 1'b0;
        strayLevel = 0;
        memLatency = 2;
        runSteps(60);
        checkQuiet("drain");

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/program_mem_controller.md
PROGRAM_MEM_CONTROLLER -- requirements
Module: program_mem_controller

Interface
REQ-001 SHALL have parameter ADDR_BITS, default 8, program memory address width.
REQ-002 SHALL have parameter DATA_BITS, default 16, instruction word width.
REQ-003 SHALL have parameter NUM_CONSUMERS, default 4, number of fetcher channels served.
REQ-004 SHALL have port clk  input  1  clock; all state updates on rising edge.
REQ-005 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port consumer_read_valid  input  NUM_CONSUMERS  per-fetcher request; held high until that channel's ready is seen.
REQ-007 SHALL have port consumer_read_address  input  NUM_CONSUMERS x ADDR_BITS  per-fetcher PC, stable while valid.
REQ-008 SHALL have port consumer_read_ready  output  NUM_CONSUMERS  per-fetcher response strobe.
REQ-009 SHALL have port consumer_read_data  output  NUM_CONSUMERS x DATA_BITS  per-fetcher instruction word.
REQ-010 SHALL have port mem_read_valid  output  1  request to program memory.
REQ-011 SHALL have port mem_read_address  output  ADDR_BITS  address to program memory.
REQ-012 SHALL have port mem_read_ready  input  1  memory response strobe, meaningful only while mem_read_valid is high.
REQ-013 SHALL have port mem_read_data  input  DATA_BITS  memory data, valid in the cycle mem_read_ready is high.

Function
REQ-014 SHALL run one FSM: IDLE, READ_WAITING, RELAYING; one memory transaction outstanding at most.
REQ-015 IDLE: SHALL pick the first channel with valid high, searching from rr_ptr upward modulo NUM_CONSUMERS; on a pick, latch its id and address, drive mem_read_valid=1 and mem_read_address=address from the next cycle, go READ_WAITING.
REQ-016 IDLE with no valid request: SHALL stay IDLE with all ready outputs and mem_read_valid at 0.
REQ-017 READ_WAITING: SHALL hold mem_read_valid and mem_read_address stable until mem_read_ready is sampled high, with no timeout.
REQ-018 On mem_read_ready in READ_WAITING: SHALL register mem_read_data into consumer_read_data[id], set consumer_read_ready[id]=1, clear mem_read_valid, go RELAYING.
REQ-019 RELAYING: SHALL hold ready[id] and data[id] until consumer_read_valid[id] is sampled low; then clear ready[id], set rr_ptr=(id+1) mod NUM_CONSUMERS, go IDLE.
REQ-020 SHALL not re-grant a channel whose valid is still high from a completed request (guaranteed by REQ-019).
REQ-021 If the granted channel drops valid during READ_WAITING: SHALL still complete the memory read; ready[id] is then high exactly one cycle.
REQ-022 SHALL ignore mem_read_ready while mem_read_valid is low.
REQ-023 consumer_read_data[i] SHALL retain its last value after ready drops; non-granted channels' outputs SHALL never change.
REQ-024 With a zero-wait memory (ready high in the same cycle as valid) and a fetcher clearing valid one cycle after it sees ready, a transaction SHALL take 4 cycles from valid-sampled to IDLE.

Reset
REQ-025 On reset: state=IDLE, rr_ptr=0, mem_read_valid=0, mem_read_address=0, all consumer_read_ready=0, all consumer_read_data=0.
REQ-026 Reset mid-transaction SHALL abandon it without a response; a still-valid fetcher is re-served after reset.

Structure
REQ-027 The state enum (2-bit: IDLE=0, READ_WAITING=1, RELAYING=2) SHALL live in package program_mem_controller_pkg.
REQ-028 Round-robin selection SHALL be the sub-module rr_arbiter (inputs: request vector, rr_ptr; outputs: grant_valid, grant_id).

Verification
REQ-029 Single read: ch0 valid, addr 0x05; memory returns 0x1234 after 2 cycles -> mem_read_address=0x05; ready[0] high with data[0]=0x1234; returns to IDLE after valid[0] drops.
REQ-030 Contention: ch0..ch3 valid together after reset -> service order 0,1,2,3; with ch0 re-requesting immediately, order 1,2,3,0.
REQ-031 Held valid: ch2 keeps valid high 5 cycles after ready -> ready[2] held 5 cycles; no second memory read for ch2.
REQ-032 Abandon: ch1 drops valid while READ_WAITING -> read completes; ready[1] high exactly 1 cycle; IDLE next.
REQ-033 Reset during READ_WAITING with ch3 valid -> all outputs 0 next cycle; ch3 re-served with its address after reset.
REQ-034 Stray mem_read_ready in IDLE -> no state change, no ready output.
